dpll_lock_sequencer: RTL and testbench
======================================

# dpll_lock_sequencer

Lock-acquisition controller for the M-sequence DPLL clock-recovery loop, running in the 2 MHz system clock domain. It qualifies the gate-measured input frequency, loads the NCO base increment, and pulses an integrator clear. It drives wide acquisition gains until the loop reports lock, then switches to narrow tracking gains. It detects loss of lock and frequency drift, re-enters measurement, and counts relock events for status.

## Interface
- CLK_FREQ, 2000000: system clock frequency in Hz, informational only.
- FREQ_MIN, 10000: lowest accepted input frequency in Hz.
- FREQ_MAX, 100000: highest accepted input frequency in Hz.
- FREQ_TOL, 50: maximum allowed difference in Hz between two consecutive measurements.
- INC_MULT, 2147: NCO increment per Hz.
- KP_ACQ, 8'h20 / KI_ACQ, 8'h08: acquisition gains.
- KP_TRK, 8'h10 / KI_TRK, 8'h05: tracking gains.
- LOCK_HOLD, 2000: consecutive `pll_locked` high cycles needed to declare lock (1 ms).
- LOSS_HOLD, 200: consecutive `pll_locked` low cycles needed to declare loss.
- ACQ_TIMEOUT, 4000000: acquisition time limit in cycles (2 s).
- clk_2m  in  1  system clock; the only clock.
- rst  in  1  reset; asynchronous, active-high.
- enable  in  1  run request; level-sensitive.
- freq_value  in  32  measured frequency in Hz; valid only when `freq_valid` is high.
- freq_valid  in  1  one-cycle strobe, once per gate window.
- pll_locked  in  1  lock flag from the DPLL core.
- init_inc  out  32  NCO base increment.
- loop_kp  out  8  proportional gain to the loop.
- loop_ki  out  8  integral gain to the loop.
- loop_clear  out  1  one-cycle pulse; clears the integrator and phase registers.
- seq_state  out  3  current state encoding.
- seq_locked  out  1  high while in TRACK.
- relock_cnt  out  8  saturating count of relock events.
- fault  out  1  last measurement was out of range.

## Operation
- States: IDLE=0, MEASURE=1, LOAD=2, ACQUIRE=3, TRACK=4.
- IDLE:
  - `enable` high -> MEASURE.
  - Clears `have_ref`.
- MEASURE, on `freq_valid`:
  - `freq_value` outside [FREQ_MIN, FREQ_MAX]: set `fault`, clear `have_ref`, stay.
  - In range and no `have_ref`: store `freq_ref`, set `have_ref`, clear `fault`, stay.
  - In range, `have_ref` set, |freq_value - freq_ref| <= FREQ_TOL: store `freq_ref` <= freq_value, clear `fault`, go to LOAD.
  - In range, `have_ref` set, difference > FREQ_TOL: store the new value as `freq_ref`, stay.
- LOAD: exactly one cycle; then ACQUIRE.
  - init_inc <= freq_ref * INC_MULT, truncated to 32 bits.
  - loop_kp/loop_ki <= KP_ACQ/KI_ACQ.
  - loop_clear = 1.
  - Clears the timeout and qualify counters.
- ACQUIRE:
  - Timeout counter increments every cycle.
  - Qualify counter increments while `pll_locked` is high and clears when it is low.
  - Qualify counter reaches LOCK_HOLD-1 with `pll_locked` high -> TRACK; loop_kp/loop_ki <= KP_TRK/KI_TRK.
  - Timeout counter reaches ACQ_TIMEOUT-1 -> MEASURE, relock_cnt++, clear `have_ref`.
  - Lock qualification and timeout in the same cycle: lock wins.
- TRACK:
  - Loss counter counts consecutive `pll_locked` low cycles.
  - Loss counter reaches LOSS_HOLD-1 -> MEASURE.
  - `freq_valid` with |freq_value - freq_ref| > FREQ_TOL -> MEASURE.
  - Either exit: relock_cnt increments once, even if both occur in the same cycle; `have_ref` clears.
- `enable` low in any state -> IDLE on the next edge.
  - loop_kp/loop_ki return to ACQ values; init_inc holds; relock_cnt and fault hold.
- relock_cnt saturates at 8'hFF.
- Frequency difference is computed as a 33-bit signed value, then its absolute value is taken.
- The FREQ_MAX*INC_MULT product must fit in 32 bits.

## Timing
- All outputs are registered and update on the same clk_2m edge as the state transition that causes them.
- `freq_valid` to state change: 1 cycle.
- `loop_clear` is high for exactly the one cycle in which `seq_state`=LOAD.
- `seq_locked` rises on the edge entering TRACK and falls on the edge leaving it.
- `rst` asserted at any time takes effect immediately, even mid-ACQUIRE or mid-TRACK. Reset values:
  - state IDLE, init_inc 0.
  - loop_kp KP_ACQ, loop_ki KI_ACQ.
  - loop_clear 0, seq_locked 0, relock_cnt 0, fault 0.
  - all internal counters 0, `have_ref` 0.

## Structure
- Shared package `dpll_pkg` holds:
  - state encodings;
  - CLK_FREQ and INC_MULT;
  - default gain constants, shared with the DPLL core.
- Sub-module `dpll_qual_counter` is a run-length counter: inputs `level`, `clr`, threshold; output is a `hit` strobe. It is instantiated twice, once for lock qualification and once for loss detection.
- The timeout counter and FSM are inline.

## Test plan
- Enable; two `freq_valid` strobes with 10000 -> LOAD; init_inc=21470000; one-cycle loop_clear; kp=0x20, ki=0x08.
- Hold `pll_locked` high for 2000 cycles in ACQUIRE -> TRACK; kp=0x10, ki=0x05; seq_locked=1. A low glitch at cycle 1500 restarts qualification.
- In TRACK, drop `pll_locked` for 200 cycles -> MEASURE; relock_cnt=1; seq_locked=0. A 199-cycle drop keeps TRACK.
- Measurements 5000 then 10000, 10030 -> fault=1 then cleared; LOAD occurs after 10030; init_inc=21534410.
- No lock for 4000000 cycles -> MEASURE with relock_cnt++. Drive 260 timeouts -> relock_cnt stays 0xFF.
- Assert `rst` mid-ACQUIRE -> all outputs at reset values immediately. Deassert `enable` in TRACK -> IDLE next edge; kp=0x20.

Source files
------------

// File: rtl/dpll_pkg.sv
// Shared definitions for the DPLL clock-recovery loop.
// Holds the lock-sequencer state encoding, the NCO scaling factor, and the
// default loop gains. The gains are also used by the DPLL core.
package dpll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEASURE = 3'd1,
        ST_LOAD    = 3'd2,
        ST_ACQUIRE = 3'd3,
        ST_TRACK   = 3'd4
    } seq_state_e;

    localparam int unsigned CLK_FREQ = 2000000;
    localparam logic [31:0] INC_MULT = 32'd2147;

    localparam logic [7:0] KP_ACQ = 8'h20;
    localparam logic [7:0] KI_ACQ = 8'h08;
    localparam logic [7:0] KP_TRK = 8'h10;
    localparam logic [7:0] KI_TRK = 8'h05;

    // |a - b| for two unsigned 32-bit frequencies.
    // The difference is formed as a 33-bit signed value, so it cannot wrap.
    function automatic logic [32:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? -d : d;
    endfunction

endpackage

// File: rtl/dpll_lock_sequencer_qual.sv
// dpll_qual_counter: run-length counter.
// The counter counts consecutive cycles in which `level` is high.
// `hit` is asserted during the cycle that completes a run of `threshold`
// cycles. Any low cycle restarts the run, and so does `clr`.
// Ports:
//   clk_2m, rst - clock and asynchronous active-high reset
//   level       - condition being qualified
//   clr         - synchronous clear; also masks `hit`
//   threshold   - required run length in cycles (must be >= 1)
//   hit         - combinational strobe on the completing cycle
module dpll_qual_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_2m,
    input  logic         rst,
    input  logic         level,
    input  logic         clr,
    input  logic [W-1:0] threshold,
    output logic         hit
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_last;

    assign at_last = (cnt_q == threshold - ONE);
    assign hit     = level && !clr && at_last;

    // The counter saturates at threshold-1. If the owner is slow to react,
    // the count then holds instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !level) begin
            cnt_d = '0;
        end else if (!at_last) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_2m or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dpll_lock_sequencer.sv
// dpll_lock_sequencer: lock-acquisition controller for the DPLL loop.
//
// Operation:
//   - Qualifies two consecutive gate measurements of the input frequency.
//   - Loads the NCO base increment and pulses the integrator clear.
//   - Runs wide acquisition gains until lock is qualified, then narrow
//     tracking gains.
//   - Re-measures on loss of lock, frequency drift, or acquisition timeout.
//   - Counts relock events.
//
// Ports:
//   clk_2m, rst               - 2 MHz system clock, asynchronous active-high reset
//   enable                    - run request (level)
//   freq_value, freq_valid    - gate measurement in Hz and its one-cycle strobe
//   pll_locked                - raw lock flag from the DPLL core
//   init_inc                  - NCO base increment
//   loop_kp, loop_ki          - loop gains
//   loop_clear                - one-cycle integrator/phase clear
//   seq_state                 - current state encoding
//   seq_locked                - high while tracking
//   relock_cnt                - saturating relock count
//   fault                     - last measurement was out of range
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | disabled; reference measurement forgotten
// MEASURE | waiting for two consecutive in-range, in-tolerance gates
// LOAD    | one cycle: NCO increment and acquisition gains applied, loop cleared
// ACQUIRE | wide gains; waiting for a qualified lock or a timeout
// TRACK   | narrow gains; watching for loss of lock or drift
module dpll_lock_sequencer
    import dpll_pkg::*;
#(
    parameter int unsigned FREQ_MIN    = 10000,
    parameter int unsigned FREQ_MAX    = 100000,
    parameter int unsigned FREQ_TOL    = 50,
    parameter int unsigned LOCK_HOLD   = 2000,
    parameter int unsigned LOSS_HOLD   = 200,
    parameter int unsigned ACQ_TIMEOUT = 4000000
) (
    input  logic        clk_2m,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] freq_value,
    input  logic        freq_valid,
    input  logic        pll_locked,
    output logic [31:0] init_inc,
    output logic [7:0]  loop_kp,
    output logic [7:0]  loop_ki,
    output logic        loop_clear,
    output logic [2:0]  seq_state,
    output logic        seq_locked,
    output logic [7:0]  relock_cnt,
    output logic        fault
);

    localparam int unsigned QW       = 16;
    localparam logic [QW-1:0] LOCK_THR = QW'(LOCK_HOLD);
    localparam logic [QW-1:0] LOSS_THR = QW'(LOSS_HOLD);
    localparam logic [31:0] FMIN     = 32'(FREQ_MIN);
    localparam logic [31:0] FMAX     = 32'(FREQ_MAX);
    localparam logic [32:0] TOL      = 33'(FREQ_TOL);
    localparam logic [31:0] TMO_LAST = 32'(ACQ_TIMEOUT - 1);

    // The NCO increment register is 32 bits wide.
    // The largest accepted frequency must not overflow it.
    if (64'(FREQ_MAX) * 64'(INC_MULT) > 64'hFFFF_FFFF) begin : g_inc_overflow
        $error("FREQ_MAX * INC_MULT does not fit the 32-bit NCO increment");
    end

    seq_state_e  state_q,      state_d;
    logic [31:0] freq_ref_q,   freq_ref_d;
    logic        have_ref_q,   have_ref_d;
    logic [31:0] tmo_q,        tmo_d;
    logic [31:0] init_inc_q,   init_inc_d;
    logic [7:0]  kp_q,         kp_d;
    logic [7:0]  ki_q,         ki_d;
    logic        loop_clear_q, loop_clear_d;
    logic        seq_locked_q, seq_locked_d;
    logic [7:0]  relock_q,     relock_d;
    logic        fault_q,      fault_d;

    logic        lock_hit;
    logic        loss_hit;
    logic        lock_clr;
    logic        loss_clr;
    logic        in_range;
    logic        drift;
    logic [32:0] diff_abs;

    assign lock_clr = (state_q != ST_ACQUIRE);
    assign loss_clr = (state_q != ST_TRACK);

    dpll_qual_counter #(.W(QW)) u_lock_qual (
        .clk_2m    (clk_2m),
        .rst       (rst),
        .level     (pll_locked),
        .clr       (lock_clr),
        .threshold (LOCK_THR),
        .hit       (lock_hit)
    );

    dpll_qual_counter #(.W(QW)) u_loss_qual (
        .clk_2m    (clk_2m),
        .rst       (rst),
        .level     (!pll_locked),
        .clr       (loss_clr),
        .threshold (LOSS_THR),
        .hit       (loss_hit)
    );

    assign diff_abs = abs_diff(freq_value, freq_ref_q);
    assign in_range = (freq_value >= FMIN) && (freq_value <= FMAX);
    assign drift    = (diff_abs > TOL);

    always_comb begin
        state_d    = state_q;
        freq_ref_d = freq_ref_q;
        have_ref_d = have_ref_q;
        tmo_d      = '0;
        init_inc_d = init_inc_q;
        kp_d       = kp_q;
        ki_d       = ki_q;
        relock_d   = relock_q;
        fault_d    = fault_q;

        case (state_q)
            ST_IDLE: begin
                have_ref_d = 1'b0;
                if (enable) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (freq_valid) begin
                    if (!in_range) begin
                        fault_d    = 1'b1;
                        have_ref_d = 1'b0;
                    end else begin
                        fault_d    = 1'b0;
                        freq_ref_d = freq_value;
                        have_ref_d = 1'b1;
                        if (have_ref_q && !drift) begin
                            // freq_value becomes freq_ref on this edge.
                            // Scale it directly so the increment is valid
                            // in the LOAD cycle.
                            state_d    = ST_LOAD;
                            init_inc_d = freq_value * INC_MULT;
                            kp_d       = KP_ACQ;
                            ki_d       = KI_ACQ;
                        end
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                tmo_d = tmo_q + 32'd1;
                // A qualified lock takes priority over a simultaneous timeout.
                if (lock_hit) begin
                    state_d = ST_TRACK;
                    kp_d    = KP_TRK;
                    ki_d    = KI_TRK;
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = ST_MEASURE;
                    have_ref_d = 1'b0;
                    if (relock_q != 8'hFF) begin
                        relock_d = relock_q + 8'd1;
                    end
                end
            end
            ST_TRACK: begin
                if (loss_hit || (freq_valid && drift)) begin
                    state_d    = ST_MEASURE;
                    have_ref_d = 1'b0;
                    if (relock_q != 8'hFF) begin
                        relock_d = relock_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping enable overrides everything else decided this cycle.
        // Status, the reference and the increment are left as they were.
        if (!enable) begin
            state_d    = ST_IDLE;
            freq_ref_d = freq_ref_q;
            have_ref_d = 1'b0;
            tmo_d      = '0;
            init_inc_d = init_inc_q;
            kp_d       = KP_ACQ;
            ki_d       = KI_ACQ;
            relock_d   = relock_q;
            fault_d    = fault_q;
        end

        loop_clear_d = (state_d == ST_LOAD);
        seq_locked_d = (state_d == ST_TRACK);
    end

    always_ff @(posedge clk_2m or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            freq_ref_q   <= '0;
            have_ref_q   <= 1'b0;
            tmo_q        <= '0;
            init_inc_q   <= '0;
            kp_q         <= KP_ACQ;
            ki_q         <= KI_ACQ;
            loop_clear_q <= 1'b0;
            seq_locked_q <= 1'b0;
            relock_q     <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            freq_ref_q   <= freq_ref_d;
            have_ref_q   <= have_ref_d;
            tmo_q        <= tmo_d;
            init_inc_q   <= init_inc_d;
            kp_q         <= kp_d;
            ki_q         <= ki_d;
            loop_clear_q <= loop_clear_d;
            seq_locked_q <= seq_locked_d;
            relock_q     <= relock_d;
            fault_q      <= fault_d;
        end
    end

    assign seq_state  = state_q;
    assign init_inc   = init_inc_q;
    assign loop_kp    = kp_q;
    assign loop_ki    = ki_q;
    assign loop_clear = loop_clear_q;
    assign seq_locked = seq_locked_q;
    assign relock_cnt = relock_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_dpll_lock_sequencer.sv
module tb_dpll_lock_sequencer;

    // Lock hold and timeout are scaled down so that timeout saturation
    // completes in a short run. The loss hold keeps its real value.
    localparam int unsigned T_LOCK = 64;
    localparam int unsigned T_LOSS = 200;
    localparam int unsigned T_TMO  = 120;
    localparam int unsigned F_MIN  = 10000;
    localparam int unsigned F_MAX  = 100000;
    localparam int unsigned F_TOL  = 50;
    localparam int unsigned MULT   = 2147;

    logic        clk_2m = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] freq_value = '0;
    logic        freq_valid = 1'b0;
    logic        pll_locked = 1'b0;
    logic [31:0] init_inc;
    logic [7:0]  loop_kp, loop_ki, relock_cnt;
    logic        loop_clear, seq_locked, fault;
    logic [2:0]  seq_state;

    int total = 0;
    int bad = 0;

    // Scenario-level model of the status outputs.
    int          m_relock = 0;
    logic [31:0] m_inc = '0;
    logic        m_fault = 1'b0;

    dpll_lock_sequencer #(
        .LOCK_HOLD(T_LOCK), .LOSS_HOLD(T_LOSS), .ACQ_TIMEOUT(T_TMO)
    ) dut (
        .clk_2m(clk_2m), .rst(rst), .enable(enable),
        .freq_value(freq_value), .freq_valid(freq_valid), .pll_locked(pll_locked),
        .init_inc(init_inc), .loop_kp(loop_kp), .loop_ki(loop_ki),
        .loop_clear(loop_clear), .seq_state(seq_state), .seq_locked(seq_locked),
        .relock_cnt(relock_cnt), .fault(fault)
    );

    always #5 clk_2m = ~clk_2m;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_inc(input int unsigned f);
        logic [63:0] p;
        p = 64'(f) * 64'(MULT);
        return p[31:0];
    endfunction

    function automatic int unsigned absd(input int unsigned a, input int unsigned b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic step();
        @(posedge clk_2m);
        #1;
    endtask

    task automatic strobe(input int unsigned f);
        freq_value = f;
        freq_valid = 1'b1;
        step();
        freq_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; pll_locked = 1'b0; freq_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        m_relock = 0; m_inc = '0; m_fault = 1'b0;
    endtask

    task automatic to_idle();
        enable = 1'b0; pll_locked = 1'b0;
        step();
    endtask

    task automatic to_load(input int unsigned f);
        enable = 1'b1;
        step();
        strobe(f);
        strobe(f);
        m_inc = exp_inc(f);
        m_fault = 1'b0;
    endtask

    task automatic to_track(input int unsigned f);
        to_load(f);
        step();
        pll_locked = 1'b1;
        repeat (T_LOCK) step();
    endtask

    task automatic test_reset();
        do_reset();
        step();
        total++; if (seq_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", seq_state); end
        total++; if (init_inc !== 32'd0) begin bad++; $display("FAIL reset_inc got=%0d exp=0", init_inc); end
        total++; if ({loop_kp, loop_ki} !== 16'h2008) begin bad++; $display("FAIL reset_gains got=%h exp=2008", {loop_kp, loop_ki}); end
        total++; if ({loop_clear, seq_locked, fault} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {loop_clear, seq_locked, fault}); end
        total++; if (relock_cnt !== 8'd0) begin bad++; $display("FAIL reset_relock got=%0d exp=0", relock_cnt); end
    endtask

    task automatic test_load();
        int unsigned f;
        for (int it = 0; it < 6; it++) begin
            f = (it == 0) ? 10000 : (it == 1) ? F_MAX : (it == 2) ? F_MIN : $urandom_range(F_MAX, F_MIN);
            do_reset();
            to_load(f);
            total++; if (seq_state !== 3'd2) begin bad++; $display("FAIL load_state f=%0d got=%0d exp=2", f, seq_state); end
            total++; if (loop_clear !== 1'b1) begin bad++; $display("FAIL load_clear f=%0d got=%b exp=1", f, loop_clear); end
            total++; if (init_inc !== m_inc) begin bad++; $display("FAIL load_inc f=%0d got=%0d exp=%0d", f, init_inc, m_inc); end
            total++; if ({loop_kp, loop_ki} !== 16'h2008) begin bad++; $display("FAIL load_gains got=%h exp=2008", {loop_kp, loop_ki}); end
            step();
            total++; if (seq_state !== 3'd3 || loop_clear !== 1'b0) begin bad++; $display("FAIL load_next got state=%0d clear=%b exp state=3 clear=0", seq_state, loop_clear); end
        end
        total++; if (exp_inc(10000) !== 32'd21470000) begin bad++; $display("FAIL inc_model got=%0d exp=21470000", exp_inc(10000)); end
    endtask

    task automatic test_measure();
        int unsigned seq[$];
        int unsigned f, ref_f;
        logic have;
        int exp_st;
        do_reset();
        enable = 1'b1;
        step();
        strobe(5000);
        total++; if (fault !== 1'b1 || seq_state !== 3'd1) begin bad++; $display("FAIL meas_low got fault=%b state=%0d exp fault=1 state=1", fault, seq_state); end
        strobe(10000);
        total++; if (fault !== 1'b0 || seq_state !== 3'd1) begin bad++; $display("FAIL meas_first got fault=%b state=%0d exp fault=0 state=1", fault, seq_state); end
        strobe(10030);
        total++; if (seq_state !== 3'd2 || init_inc !== 32'd21534410) begin bad++; $display("FAIL meas_load got state=%0d inc=%0d exp state=2 inc=21534410", seq_state, init_inc); end
        m_inc = 32'd21534410;
        for (int s = 0; s < 6; s++) begin
            to_idle();
            enable = 1'b1;
            step();
            have = 1'b0;
            ref_f = 0;
            for (int n = 0; n < 12; n++) begin
                case ($urandom_range(5, 0))
                    0: f = (n % 2 == 0) ? F_MIN - 1 : F_MAX + 1;
                    1: f = $urandom_range(F_MIN - 1, 0);
                    2: f = $urandom_range(F_MAX + 5000, F_MAX + 1);
                    3: f = $urandom_range(F_MAX, F_MIN);
                    default: begin
                        if (!have) f = $urandom_range(F_MAX - 100, F_MIN + 100);
                        else if ($urandom_range(1, 0) == 1) f = ref_f + $urandom_range(60, 0);
                        else f = ref_f - $urandom_range(60, 0);
                    end
                endcase
                if (f < F_MIN || f > F_MAX) begin m_fault = 1'b1; have = 1'b0; exp_st = 1; end
                else if (!have) begin have = 1'b1; ref_f = f; m_fault = 1'b0; exp_st = 1; end
                else if (absd(f, ref_f) <= F_TOL) begin m_fault = 1'b0; exp_st = 2; end
                else begin ref_f = f; m_fault = 1'b0; exp_st = 1; end
                strobe(f);
                total++; if (seq_state !== 3'(exp_st) || fault !== m_fault) begin bad++; $display("FAIL meas_rand f=%0d got state=%0d fault=%b exp state=%0d fault=%b", f, seq_state, fault, exp_st, m_fault); end
                if (exp_st == 2) begin
                    m_inc = exp_inc(f);
                    total++; if (init_inc !== m_inc) begin bad++; $display("FAIL meas_rand_inc got=%0d exp=%0d", init_inc, m_inc); end
                    break;
                end
            end
        end
        to_idle();
    endtask

    task automatic test_lock();
        int g, exit_k, lock_k, exp_k, exp_st;
        int unsigned glist[$];
        glist = '{30, 0, 55, 56, 1};
        repeat (3) glist.push_back($urandom_range(56, 0));
        foreach (glist[i]) begin
            g = int'(glist[i]);
            to_idle();
            to_load($urandom_range(F_MAX, F_MIN));
            pll_locked = 1'b0;
            step();
            exit_k = -1;
            for (int k = 1; k <= int'(T_TMO) + 5; k++) begin
                pll_locked = (k != g + 1);
                step();
                if (seq_state !== 3'd3) begin exit_k = k; break; end
            end
            lock_k = g + 1 + int'(T_LOCK);
            if (lock_k <= int'(T_TMO)) begin exp_k = lock_k; exp_st = 4; end
            else begin exp_k = int'(T_TMO); exp_st = 1; m_relock = sat_inc(m_relock); end
            total++; if (exit_k != exp_k) begin bad++; $display("FAIL lock_cycle g=%0d got=%0d exp=%0d", g, exit_k, exp_k); end
            total++; if (seq_state !== 3'(exp_st) || seq_locked !== (exp_st == 4)) begin bad++; $display("FAIL lock_state g=%0d got state=%0d locked=%b exp state=%0d", g, seq_state, seq_locked, exp_st); end
            total++; if ({loop_kp, loop_ki} !== ((exp_st == 4) ? 16'h1005 : 16'h2008)) begin bad++; $display("FAIL lock_gains g=%0d got=%h", g, {loop_kp, loop_ki}); end
            total++; if (relock_cnt !== 8'(m_relock)) begin bad++; $display("FAIL lock_relock got=%0d exp=%0d", relock_cnt, m_relock); end
        end
        to_idle();
    endtask

    task automatic test_loss();
        int d, exit_k, exp_k;
        int unsigned dlist[$];
        dlist = '{199, 200, 1};
        repeat (3) dlist.push_back($urandom_range(260, 1));
        foreach (dlist[i]) begin
            d = int'(dlist[i]);
            to_idle();
            to_track($urandom_range(F_MAX, F_MIN));
            total++; if (seq_locked !== 1'b1) begin bad++; $display("FAIL loss_pre got locked=%b exp=1", seq_locked); end
            pll_locked = 1'b0;
            exit_k = -1;
            for (int k = 1; k <= d; k++) begin
                step();
                if (seq_state !== 3'd4) begin exit_k = k; break; end
            end
            exp_k = (d >= int'(T_LOSS)) ? int'(T_LOSS) : -1;
            if (exp_k > 0) m_relock = sat_inc(m_relock);
            pll_locked = 1'b1;
            step();
            total++; if (exit_k != exp_k) begin bad++; $display("FAIL loss_cycle d=%0d got=%0d exp=%0d", d, exit_k, exp_k); end
            total++; if (seq_state !== ((exp_k > 0) ? 3'd1 : 3'd4)) begin bad++; $display("FAIL loss_state d=%0d got=%0d", d, seq_state); end
            total++; if (relock_cnt !== 8'(m_relock) || seq_locked !== (exp_k < 0)) begin bad++; $display("FAIL loss_status d=%0d got relock=%0d locked=%b exp relock=%0d", d, relock_cnt, seq_locked, m_relock); end
        end
        to_idle();
    endtask

    task automatic test_drift();
        int unsigned f;
        int delta;
        int dl[$];
        logic leave;
        dl = '{50, -50, 51, -51, 0};
        repeat (3) dl.push_back(int'($urandom_range(240, 0)) - 120);
        foreach (dl[i]) begin
            delta = dl[i];
            f = $urandom_range(F_MAX - 200, F_MIN + 200);
            to_idle();
            to_track(f);
            repeat (3) step();
            strobe(int'(f) + delta);
            leave = (absd(int'(f) + delta, f) > F_TOL);
            if (leave) m_relock = sat_inc(m_relock);
            total++; if (seq_state !== (leave ? 3'd1 : 3'd4)) begin bad++; $display("FAIL drift_state delta=%0d got=%0d", delta, seq_state); end
            total++; if (relock_cnt !== 8'(m_relock)) begin bad++; $display("FAIL drift_relock delta=%0d got=%0d exp=%0d", delta, relock_cnt, m_relock); end
        end
        to_idle();
    endtask

    task automatic test_back_to_back();
        int unsigned f;
        f = 40000;
        to_idle();
        to_track(f);
        pll_locked = 1'b0;
        repeat (T_LOSS - 1) step();
        strobe(f + 1000);
        m_relock = sat_inc(m_relock);
        total++; if (seq_state !== 3'd1 || relock_cnt !== 8'(m_relock)) begin bad++; $display("FAIL both_exit got state=%0d relock=%0d exp state=1 relock=%0d", seq_state, relock_cnt, m_relock); end
        to_idle();
    endtask

    task automatic test_enable_drop();
        to_track(77777);
        enable = 1'b0;
        step();
        total++; if (seq_state !== 3'd0 || seq_locked !== 1'b0) begin bad++; $display("FAIL en_state got state=%0d locked=%b exp state=0 locked=0", seq_state, seq_locked); end
        total++; if ({loop_kp, loop_ki} !== 16'h2008) begin bad++; $display("FAIL en_gains got=%h exp=2008", {loop_kp, loop_ki}); end
        total++; if (init_inc !== m_inc || relock_cnt !== 8'(m_relock)) begin bad++; $display("FAIL en_hold got inc=%0d relock=%0d exp inc=%0d relock=%0d", init_inc, relock_cnt, m_inc, m_relock); end
    endtask

    task automatic test_timeout_saturation();
        for (int i = 0; i < 260; i++) begin
            to_idle();
            to_load($urandom_range(F_MAX, F_MIN));
            step();
            pll_locked = 1'b0;
            repeat (T_TMO) step();
            m_relock = sat_inc(m_relock);
            total++; if (seq_state !== 3'd1 || relock_cnt !== 8'(m_relock)) begin bad++; $display("FAIL tmo_iter i=%0d got state=%0d relock=%0d exp state=1 relock=%0d", i, seq_state, relock_cnt, m_relock); end
        end
        total++; if (relock_cnt !== 8'hFF) begin bad++; $display("FAIL tmo_sat got=%0d exp=255", relock_cnt); end
        to_idle();
    endtask

    task automatic test_async_reset();
        for (int v = 0; v < 2; v++) begin
            to_idle();
            if (v == 0) begin to_load(25000); step(); repeat (10) step(); end
            else to_track(25000);
            #2;
            rst = 1'b1;
            #1;
            total++; if (seq_state !== 3'd0 || init_inc !== 32'd0 || relock_cnt !== 8'd0) begin bad++; $display("FAIL arst_core v=%0d got state=%0d inc=%0d relock=%0d exp 0 0 0", v, seq_state, init_inc, relock_cnt); end
            total++; if ({loop_kp, loop_ki} !== 16'h2008 || {loop_clear, seq_locked, fault} !== 3'b000) begin bad++; $display("FAIL arst_out v=%0d got gains=%h flags=%b", v, {loop_kp, loop_ki}, {loop_clear, seq_locked, fault}); end
            step();
            rst = 1'b0;
            m_relock = 0; m_inc = '0; m_fault = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_measure();
        test_lock();
        test_loss();
        test_drift();
        test_back_to_back();
        test_enable_drop();
        test_timeout_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
